chip_demod: RTL and testbench
=============================

CHIP_DEMOD -- requirements
Module: chip_demod

Interface
REQ-001 SHALL have parameter SAMPLES_PER_CHIP, default 4, giving samples integrated per chip (legal 2..8).
REQ-002 SHALL have parameter CHIPS_PER_WORD, default 32, giving chips per output word (legal 2..32).
REQ-003 i_clk  input  1  clock; all logic SHALL be clocked on its rising edge.
REQ-004 i_rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-005 i_en  input  1  demodulator enable.
REQ-006 i_sync  input  1  chip-alignment restart strobe.
REQ-007 i_sample  input  4  signed received sample.
REQ-008 i_ref  input  4  signed sine reference sample, time-aligned with i_sample.
REQ-009 i_sample_valid  input  1  i_sample and i_ref are valid this cycle.
REQ-010 o_chips  output  CHIPS_PER_WORD  demodulated chip word.
REQ-011 o_chips_valid  output  1  o_chips holds an unconsumed word.
REQ-012 i_ready  input  1  consumer accepts o_chips this cycle.
REQ-013 o_ovf  output  1  sticky flag: a completed word was dropped.

Function
REQ-014 SHALL implement states IDLE, ACCUM, DECIDE.
REQ-015 IDLE SHALL go to ACCUM when i_en=1; any state SHALL go to IDLE when i_en=0, clearing the accumulator, sample counter and chip counter.
REQ-016 In ACCUM, each cycle with i_sample_valid=1 SHALL add the 8-bit signed product i_sample*i_ref, sign-extended, to an 11-bit signed accumulator and increment the sample counter.
REQ-017 When the sample that makes the count equal SAMPLES_PER_CHIP is accumulated, the state SHALL go to DECIDE and the sample counter SHALL clear.
REQ-018 DECIDE SHALL last exactly one cycle: chip = 1 if accumulator > 0, else 0 (accumulator = 0 gives 0).
REQ-019 In DECIDE the chip SHALL shift into bit 0 of an internal shift register (shift left), so the first chip of a word ends in bit CHIPS_PER_WORD-1.
REQ-020 A valid sample arriving in DECIDE SHALL load the accumulator with its product and set the sample counter to 1; otherwise the accumulator SHALL clear; next state SHALL be ACCUM.
REQ-021 On the DECIDE of chip CHIPS_PER_WORD, the full word (including that chip) SHALL load o_chips and o_chips_valid SHALL be 1 from the next cycle; chip counter SHALL wrap to 0.
REQ-022 A word transfers when o_chips_valid=1 and i_ready=1; o_chips_valid SHALL then drop the next cycle unless a new word loads in the same cycle, in which case it SHALL stay 1 with the new word.
REQ-023 If a word completes while o_chips_valid=1 and i_ready=0, the new word SHALL be dropped, o_chips SHALL hold, and o_ovf SHALL set.
REQ-024 o_chips SHALL be stable while o_chips_valid=1 and i_ready=0.
REQ-025 i_sync=1 (with i_en=1) SHALL clear accumulator, sample counter, chip counter, shift register and o_ovf, and force ACCUM next cycle; the sample presented that cycle SHALL be discarded; o_chips/o_chips_valid SHALL be unaffected.
REQ-026 i_sync SHALL take priority over sample accumulation and DECIDE in the same cycle.

Reset
REQ-027 On i_rst_n=0 at a clock edge: state IDLE; accumulator, counters, shift register 0; o_chips=0, o_chips_valid=0, o_ovf=0.
REQ-028 Reset mid-word SHALL discard all partial chips and any pending output word.

Configuration
REQ-029 Macro CHIP_DEMOD_SOFT_EN defined: SHALL add outputs o_soft (11-bit signed, accumulator value at the last DECIDE) and o_soft_valid (1-cycle pulse in the cycle after each DECIDE), both reset to 0.
REQ-030 Macro CHIP_DEMOD_SOFT_EN undefined: o_soft and o_soft_valid SHALL not exist; all other behaviour identical.

Verification
REQ-031 Samples 0,7,0,-7 with ref 0,7,0,-7 -> accumulator 98, chip 1.
REQ-032 Samples 0,-7,0,7 with ref 0,7,0,-7 -> accumulator -98, chip 0; all samples 0 -> chip 0.
REQ-033 32 chips alternating 1,0 with i_ready=1 -> o_chips=0xAAAAAAAA, o_chips_valid high 1 cycle after 32nd DECIDE, low next cycle.
REQ-034 i_ready=0 across two full words -> first word held, o_ovf=1, second word dropped; i_sync -> o_ovf=0.
REQ-035 i_sync after 10 chips then 32 chips of 1 -> o_chips=0xFFFFFFFF, no partial-word contamination.
REQ-036 Samples -8 with ref -8 four times (CHIP_DEMOD_SOFT_EN) -> o_soft=256, no overflow, chip 1.

Source files
------------

// File: rtl/chip_demod.sv
// chip_demod: integrate-and-dump demodulator for sine-spread chips.
// Each chip integrates SAMPLES_PER_CHIP sample*reference products. The sign
// of the sum gives the chip bit, and CHIPS_PER_WORD chips are packed
// MSB-first into an output word with a valid/ready handshake.
// Optional macro CHIP_DEMOD_SOFT_EN adds the o_soft/o_soft_valid outputs,
// which carry the accumulator value at each chip decision.
module chip_demod #(
    parameter int unsigned SAMPLES_PER_CHIP = 4,
    parameter int unsigned CHIPS_PER_WORD   = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_sync,
    input  logic [3:0]                i_sample,
    input  logic [3:0]                i_ref,
    input  logic                      i_sample_valid,
    output logic [CHIPS_PER_WORD-1:0] o_chips,
    output logic                      o_chips_valid,
    input  logic                      i_ready,
    output logic                      o_ovf
`ifdef CHIP_DEMOD_SOFT_EN
    ,
    output logic [10:0]               o_soft,
    output logic                      o_soft_valid
`endif
);

    localparam int unsigned ACC_W  = 11;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned SCNT_W = $clog2(SAMPLES_PER_CHIP);
    localparam int unsigned CCNT_W = $clog2(CHIPS_PER_WORD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [ACC_W-1:0]          acc_q;
    logic [SCNT_W-1:0]         scnt_q;
    logic [CCNT_W-1:0]         ccnt_q;
    logic [CHIPS_PER_WORD-1:0] shift_q;

    logic signed [PROD_W-1:0]  prod_c;
    logic [ACC_W-1:0]          prod_ext_c;
    logic                      chip_c;
    logic [CHIPS_PER_WORD-1:0] word_c;
    logic                      last_sample_c;
    logic                      last_chip_c;

    // Signed product, chip decision and the word as it looks after this decision
    always_comb begin
        prod_c        = $signed({{4{i_sample[3]}}, i_sample}) * $signed({{4{i_ref[3]}}, i_ref});
        prod_ext_c    = {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
        chip_c        = ~acc_q[ACC_W-1] & (|acc_q);
        word_c        = {shift_q[CHIPS_PER_WORD-2:0], chip_c};
        last_sample_c = (scnt_q == SCNT_W'(SAMPLES_PER_CHIP - 1));
        last_chip_c   = (ccnt_q == CCNT_W'(CHIPS_PER_WORD - 1));
    end

    // Demodulator FSM, accumulator, counters and output word handshake
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            scnt_q        <= '0;
            ccnt_q        <= '0;
            shift_q       <= '0;
            o_chips       <= '0;
            o_chips_valid <= 1'b0;
            o_ovf         <= 1'b0;
`ifdef CHIP_DEMOD_SOFT_EN
            o_soft        <= '0;
            o_soft_valid  <= 1'b0;
`endif
        end else begin
            // Consumed word retires unless a new word replaces it below
            if (o_chips_valid && i_ready) begin
                o_chips_valid <= 1'b0;
            end
`ifdef CHIP_DEMOD_SOFT_EN
            o_soft_valid <= 1'b0;
`endif
            if (!i_en) begin
                state_q <= IDLE;
                acc_q   <= '0;
                scnt_q  <= '0;
                ccnt_q  <= '0;
            end else if (i_sync) begin
                state_q <= ACCUM;
                acc_q   <= '0;
                scnt_q  <= '0;
                ccnt_q  <= '0;
                shift_q <= '0;
                o_ovf   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ACCUM;
                    end
                    ACCUM: begin
                        if (i_sample_valid) begin
                            acc_q <= acc_q + prod_ext_c;
                            if (last_sample_c) begin
                                scnt_q  <= '0;
                                state_q <= DECIDE;
                            end else begin
                                scnt_q <= scnt_q + SCNT_W'(1);
                            end
                        end
                    end
                    DECIDE: begin
                        shift_q <= word_c;
`ifdef CHIP_DEMOD_SOFT_EN
                        o_soft       <= acc_q;
                        o_soft_valid <= 1'b1;
`endif
                        if (last_chip_c) begin
                            ccnt_q <= '0;
                            if (!o_chips_valid || i_ready) begin
                                o_chips       <= word_c;
                                o_chips_valid <= 1'b1;
                            end else begin
                                o_ovf <= 1'b1;
                            end
                        end else begin
                            ccnt_q <= ccnt_q + CCNT_W'(1);
                        end
                        // A sample arriving here starts the next chip
                        if (i_sample_valid) begin
                            acc_q  <= prod_ext_c;
                            scnt_q <= SCNT_W'(1);
                        end else begin
                            acc_q  <= '0;
                            scnt_q <= '0;
                        end
                        state_q <= ACCUM;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chip_demod.sv
// Directed bench for chip_demod: a table of per-chip sample/reference records,
// each with a hand-computed chip bit, builds words. Hand-written sequences
// cover sync, overflow, simultaneous transfer/load, enable drop and reset.
module tb_chip_demod;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_sync;
    logic [3:0]  i_sample;
    logic [3:0]  i_ref;
    logic        i_sample_valid;
    logic [31:0] o_chips;
    logic        o_chips_valid;
    logic        i_ready;
    logic        o_ovf;
`ifdef CHIP_DEMOD_SOFT_EN
    logic [10:0] o_soft;
    logic        o_soft_valid;
`endif

    chip_demod #(.SAMPLES_PER_CHIP(4), .CHIPS_PER_WORD(32)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (i_en),
        .i_sync         (i_sync),
        .i_sample       (i_sample),
        .i_ref          (i_ref),
        .i_sample_valid (i_sample_valid),
        .o_chips        (o_chips),
        .o_chips_valid  (o_chips_valid),
        .i_ready        (i_ready),
        .o_ovf          (o_ovf)
`ifdef CHIP_DEMOD_SOFT_EN
        ,
        .o_soft         (o_soft),
        .o_soft_valid   (o_soft_valid)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One chip: four samples (first in the top nibble) plus the expected chip bit
    typedef struct packed {
        logic [15:0] smp;
        logic [15:0] rf;
        logic        exp_chip;
    } vec_t;

    vec_t tbl [8];
    int   seq [32];
    int   n_cmp;
    int   n_bad;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Four valid samples; with gap=1 one extra idle cycle covers the decision
    task automatic send_chip(input int idx, input bit gap);
        for (int k = 0; k < 4; k++) begin
            i_sample       = tbl[idx].smp[15-4*k -: 4];
            i_ref          = tbl[idx].rf[15-4*k -: 4];
            i_sample_valid = 1'b1;
            step();
        end
        i_sample_valid = 1'b0;
        i_sample       = 4'h0;
        i_ref          = 4'h0;
        if (gap) step();
    endtask

    task automatic send_seq(input bit gap, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) send_chip(seq[c], gap);
    endtask

    task automatic fill_alt(input int a, input int b);
        for (int c = 0; c < 32; c++) seq[c] = (c % 2 == 0) ? a : b;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // 0,7,0,-7 x same -> +98
        tbl[0] = '{smp: 16'h0709, rf: 16'h0709, exp_chip: 1'b1};
        // 0,-7,0,7 x 0,7,0,-7 -> -98
        tbl[1] = '{smp: 16'h0907, rf: 16'h0709, exp_chip: 1'b0};
        // all-zero samples -> 0
        tbl[2] = '{smp: 16'h0000, rf: 16'h0709, exp_chip: 1'b0};
        // -8 x -8 four times -> +256
        tbl[3] = '{smp: 16'h8888, rf: 16'h8888, exp_chip: 1'b1};
        // 1,1,1,-1 x 1 -> +2
        tbl[4] = '{smp: 16'h111F, rf: 16'h1111, exp_chip: 1'b1};
        // 1,-1,1,-1 x 1 -> 0 exactly
        tbl[5] = '{smp: 16'h1F1F, rf: 16'h1111, exp_chip: 1'b0};
        // -3,2,0,0 x 1 -> -1
        tbl[6] = '{smp: 16'hD200, rf: 16'h1111, exp_chip: 1'b0};
        // 7 x -8 four times -> -224
        tbl[7] = '{smp: 16'h7777, rf: 16'h8888, exp_chip: 1'b0};

        i_rst_n = 1'b0; i_en = 1'b1; i_sync = 1'b0; i_sample = 4'h0; i_ref = 4'h0;
        i_sample_valid = 1'b0; i_ready = 1'b1;
        step(); step();
        chk("rst_chips", o_chips, 32'h0);
        chk("rst_valid", 32'(o_chips_valid), 32'h0);
        chk("rst_ovf", 32'(o_ovf), 32'h0);
        i_rst_n = 1'b1;
        step();  // IDLE -> ACCUM

        // Table word: chip c uses record c%8
        for (int c = 0; c < 32; c++) seq[c] = c % 8;
        send_seq(1'b1, 0, 31);
        chk("tbl_valid", 32'(o_chips_valid), 32'h1);
        for (int c = 0; c < 32; c++)
            chk($sformatf("tbl_chip%0d", c), 32'(o_chips[31-c]), 32'(tbl[c % 8].exp_chip));
        step();
        chk("tbl_valid_drop", 32'(o_chips_valid), 32'h0);

        // Alternating 1,0 -> 0xAAAAAAAA
        fill_alt(0, 1);
        send_seq(1'b1, 0, 31);
        chk("alt_word", o_chips, 32'hAAAAAAAA);
        chk("alt_valid", 32'(o_chips_valid), 32'h1);
        step();
        chk("alt_valid_drop", 32'(o_chips_valid), 32'h0);

        // Back-to-back samples, next chip's first sample lands in DECIDE
        fill_alt(1, 4);
        send_seq(1'b0, 0, 31);
        step();
        chk("stream_word", o_chips, 32'h55555555);
        chk("stream_valid", 32'(o_chips_valid), 32'h1);
        step();

        // Sync after 10 chips; the sync-cycle sample must be discarded
        for (int c = 0; c < 32; c++) seq[c] = 2;
        send_seq(1'b1, 0, 9);
        i_sync = 1'b1; i_sample = 4'h8; i_ref = 4'h7; i_sample_valid = 1'b1;
        step();
        i_sync = 1'b0; i_sample = 4'h0; i_ref = 4'h0; i_sample_valid = 1'b0;
        for (int c = 0; c < 32; c++) seq[c] = 4;
        send_seq(1'b1, 0, 30);
        chk("sync_no_early_word", 32'(o_chips_valid), 32'h0);
        send_seq(1'b1, 31, 31);
        chk("sync_word", o_chips, 32'hFFFFFFFF);
        chk("sync_valid", 32'(o_chips_valid), 32'h1);
        step();

        // Overflow: consumer stalls across two words
        i_ready = 1'b0;
        fill_alt(0, 1);
        send_seq(1'b1, 0, 31);
        chk("ovf_w1_valid", 32'(o_chips_valid), 32'h1);
        chk("ovf_w1_ovf", 32'(o_ovf), 32'h0);
        for (int c = 0; c < 32; c++) seq[c] = 2;
        send_seq(1'b1, 0, 31);
        chk("ovf_hold_word", o_chips, 32'hAAAAAAAA);
        chk("ovf_hold_valid", 32'(o_chips_valid), 32'h1);
        chk("ovf_set", 32'(o_ovf), 32'h1);
        i_sync = 1'b1;
        step();
        i_sync = 1'b0;
        chk("ovf_cleared", 32'(o_ovf), 32'h0);
        chk("sync_keeps_valid", 32'(o_chips_valid), 32'h1);
        chk("sync_keeps_word", o_chips, 32'hAAAAAAAA);
        i_ready = 1'b1;
        step();
        chk("ovf_drain", 32'(o_chips_valid), 32'h0);

        // Transfer and new word load on the same edge
        i_ready = 1'b0;
        for (int c = 0; c < 32; c++) seq[c] = 4;
        send_seq(1'b1, 0, 31);
        for (int c = 0; c < 32; c++) seq[c] = 2;
        send_seq(1'b1, 0, 30);
        send_seq(1'b0, 31, 31);
        chk("stall_stable", o_chips, 32'hFFFFFFFF);
        i_ready = 1'b1;
        step();
        chk("xfer_load_valid", 32'(o_chips_valid), 32'h1);
        chk("xfer_load_word", o_chips, 32'h00000000);
        chk("xfer_load_ovf", 32'(o_ovf), 32'h0);
        step();
        chk("xfer_load_drop", 32'(o_chips_valid), 32'h0);

        // Enable drop mid-word discards partial chips
        fill_alt(2, 2);
        send_seq(1'b1, 0, 4);
        i_en = 1'b0;
        step();
        i_en = 1'b1;
        step();
        fill_alt(3, 6);
        send_seq(1'b1, 0, 31);
        chk("en_word", o_chips, 32'hAAAAAAAA);
        step();

        // Reset mid-word with a pending word
        i_ready = 1'b0;
        for (int c = 0; c < 32; c++) seq[c] = 4;
        send_seq(1'b1, 0, 31);
        send_seq(1'b1, 0, 4);
        i_rst_n = 1'b0;
        step();
        chk("midrst_chips", o_chips, 32'h0);
        chk("midrst_valid", 32'(o_chips_valid), 32'h0);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        step();
        fill_alt(2, 3);
        send_seq(1'b1, 0, 31);
        chk("postrst_word", o_chips, 32'h55555555);
        step();

`ifdef CHIP_DEMOD_SOFT_EN
        send_chip(3, 1'b1);
        chk("soft_value", 32'(o_soft), 32'd256);
        chk("soft_valid", 32'(o_soft_valid), 32'h1);
        step();
        chk("soft_pulse", 32'(o_soft_valid), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
